// File: rtl/piso_serializer.sv
// Parallel-to-serial transmitter with a one-word holding register; first bit on SOUT one enabled edge after accept.
// DIN_READY drops while a word is held; frames reload gaplessly from the holding register on the last slot.
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SOUT,
  output logic             SYNC,
  output logic             SVALID,
  output logic [CW-1:0]    BIT_IDX
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic             hold_full;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg;
  logic             last_slot;
  logic             do_load;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign DIN_READY = ~hold_full;
  assign last_slot = (BIT_IDX == CW'(WIDTH - 1));
  // A held word starts a frame from idle or directly after the last slot of the current one.
  assign do_load   = EN && hold_full && ((state == IDLE) || last_slot);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold      <= '0;
      shreg     <= '0;
      SOUT      <= 1'b0;
      SYNC      <= 1'b0;
      SVALID    <= 1'b0;
      BIT_IDX   <= '0;
    end else begin
      // The holding register is filled regardless of EN; it can only drain when the shifter loads.
      if (do_load) begin
        hold_full <= 1'b0;
      end else if (DIN_VALID && !hold_full) begin
        hold      <= DIN;
        hold_full <= 1'b1;
      end

      if (do_load) begin
        state   <= SHIFT;
        shreg   <= advance(hold);
        SOUT    <= first_bit(hold);
        SYNC    <= 1'b1;
        SVALID  <= 1'b1;
        BIT_IDX <= '0;
      end else if (EN && state == SHIFT) begin
        if (!last_slot) begin
          shreg   <= advance(shreg);
          SOUT    <= first_bit(shreg);
          SYNC    <= 1'b0;
          BIT_IDX <= BIT_IDX + CW'(1);
        end else begin
          state   <= IDLE;
          SOUT    <= 1'b0;
          SYNC    <= 1'b0;
          SVALID  <= 1'b0;
          BIT_IDX <= '0;
        end
      end
    end
  end

endmodule
